// File: rtl/id_ex_stage.sv
// id_ex_stage
// Instruction-decode stage sitting between the IF/ID register and execute.
// Branches and jumps are resolved here so the IF stage can redirect early.
// The stage also detects load-use and branch-operand hazards, can forward
// the MEM-stage ALU result into the branch compare and jr/jalr target, and
// holds the ID/EX pipeline register with bubble and flush handling.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   id_inst, id_pc4       instruction in ID and its PC+4
//   rf_rs_data/rf_rt_data register-file reads for rs/rt
//   ex_*                  EX-stage destination info (for hazard checks)
//   mem_*                 MEM-stage destination info and ALU result
//   exc_flush             exception/interrupt taken this cycle
//   stall                 hold PC and IF/ID (combinational)
//   is_branch, is_jump    redirect requests to IF (combinational)
//   jump_reg              jump target comes from a register (jr/jalr)
//   branch_dst, jump_dst  redirect targets
//   ex_*  (outputs)       ID/EX register contents, ex_valid marks real work
module id_ex_stage #(
  parameter logic [31:0] NOP_INST = 32'h0000_0000,
  parameter bit          FWD_EN   = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] id_inst,
  input  logic [31:0] id_pc4,
  input  logic [31:0] rf_rs_data,
  input  logic [31:0] rf_rt_data,
  input  logic        ex_reg_write,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_write_reg,
  input  logic        mem_reg_write,
  input  logic        mem_mem_read,
  input  logic [4:0]  mem_write_reg,
  input  logic [31:0] mem_alu_out,
  input  logic        exc_flush,
  output logic        stall,
  output logic        is_branch,
  output logic        is_jump,
  output logic        jump_reg,
  output logic [31:0] branch_dst,
  output logic [31:0] jump_dst,
  output logic [31:0] ex_inst,
  output logic [31:0] ex_pc4,
  output logic [31:0] ex_rs_data,
  output logic [31:0] ex_rt_data,
  output logic [31:0] ex_imm,
  output logic        ex_valid
);

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_REGIMM  = 6'h01;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_BLEZ    = 6'h06;
  localparam logic [5:0] OP_BGTZ    = 6'h07;
  localparam logic [5:0] FN_JR      = 6'h08;
  localparam logic [5:0] FN_JALR    = 6'h09;

  logic [5:0]  op;
  logic [5:0]  funct;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [15:0] imm16;

  assign op    = id_inst[31:26];
  assign rs    = id_inst[25:21];
  assign rt    = id_inst[20:16];
  assign imm16 = id_inst[15:0];
  assign funct = id_inst[5:0];

  logic dec_beq, dec_bne, dec_branch, dec_jr_any, dec_jump, dec_store;
  logic cmp_uses_rs, cmp_uses_rt, loaduse_uses_rt;

  assign dec_beq    = (op == OP_BEQ);
  assign dec_bne    = (op == OP_BNE);
  assign dec_branch = dec_beq || dec_bne || (op == OP_BLEZ) ||
                      (op == OP_BGTZ) || (op == OP_REGIMM);
  assign dec_jr_any = (op == OP_SPECIAL) && ((funct == FN_JR) || (funct == FN_JALR));
  assign dec_jump   = (op == OP_J) || (op == OP_JAL) || dec_jr_any;
  assign dec_store  = (op == 6'h28) || (op == 6'h29) || (op == 6'h2A) ||
                      (op == 6'h2B) || (op == 6'h2E);

  // Registers consumed in ID itself (branch compare / jr target) versus
  // registers a later stage needs from a load result.
  assign cmp_uses_rs     = dec_branch || dec_jr_any;
  assign cmp_uses_rt     = dec_beq || dec_bne;
  assign loaduse_uses_rt = (op == OP_SPECIAL) || dec_beq || dec_bne || dec_store;

  // A MEM-stage ALU result is safe to forward; a MEM-stage load is not yet
  // available, so it can only be waited for.
  logic        mem_fwd_ok;
  logic [31:0] rs_val;
  logic [31:0] rt_val;

  assign mem_fwd_ok = FWD_EN && mem_reg_write && !mem_mem_read;
  assign rs_val = (rs == 5'd0) ? 32'd0 :
                  (mem_fwd_ok && (mem_write_reg == rs)) ? mem_alu_out : rf_rs_data;
  assign rt_val = (rt == 5'd0) ? 32'd0 :
                  (mem_fwd_ok && (mem_write_reg == rt)) ? mem_alu_out : rf_rt_data;

  logic load_use_hz, ex_cmp_hz, mem_cmp_hz;

  assign load_use_hz = ex_mem_read && (ex_write_reg != 5'd0) &&
                       ((ex_write_reg == rs) || (loaduse_uses_rt && (ex_write_reg == rt)));

  assign ex_cmp_hz = ex_reg_write && (ex_write_reg != 5'd0) &&
                     ((cmp_uses_rs && (ex_write_reg == rs)) ||
                      (cmp_uses_rt && (ex_write_reg == rt)));

  assign mem_cmp_hz = mem_reg_write && (mem_mem_read || !FWD_EN) &&
                      (mem_write_reg != 5'd0) &&
                      ((cmp_uses_rs && (mem_write_reg == rs)) ||
                       (cmp_uses_rt && (mem_write_reg == rt)));

  assign stall = load_use_hz || ex_cmp_hz || mem_cmp_hz;

  // Branch condition on the selected operands; regimm uses rt[0] to pick
  // bgez over bltz.
  logic br_taken;

  always_comb begin
    br_taken = 1'b0;
    case (op)
      OP_BEQ:    br_taken = (rs_val == rt_val);
      OP_BNE:    br_taken = (rs_val != rt_val);
      OP_BLEZ:   br_taken = rs_val[31] || (rs_val == 32'd0);
      OP_BGTZ:   br_taken = !rs_val[31] && (rs_val != 32'd0);
      OP_REGIMM: br_taken = rt[0] ? !rs_val[31] : rs_val[31];
      default:   br_taken = 1'b0;
    endcase
  end

  logic redirect_ok;

  assign redirect_ok = !stall && !exc_flush;
  assign is_branch   = dec_branch && br_taken && redirect_ok;
  assign is_jump     = dec_jump && redirect_ok;
  assign jump_reg    = dec_jr_any;
  assign branch_dst  = id_pc4 + {{14{imm16[15]}}, imm16, 2'b00};
  assign jump_dst    = dec_jr_any ? rs_val : {id_pc4[31:28], id_inst[25:0], 2'b00};

  // ID/EX register. A flush and a stall both leave a NOP bubble with all
  // data fields cleared, so they share one branch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_inst    <= NOP_INST;
      ex_pc4     <= 32'd0;
      ex_rs_data <= 32'd0;
      ex_rt_data <= 32'd0;
      ex_imm     <= 32'd0;
      ex_valid   <= 1'b0;
    end else if (exc_flush || stall) begin
      ex_inst    <= NOP_INST;
      ex_pc4     <= 32'd0;
      ex_rs_data <= 32'd0;
      ex_rt_data <= 32'd0;
      ex_imm     <= 32'd0;
      ex_valid   <= 1'b0;
    end else begin
      ex_inst    <= id_inst;
      ex_pc4     <= id_pc4;
      ex_rs_data <= rs_val;
      ex_rt_data <= rt_val;
      ex_imm     <= {{16{imm16[15]}}, imm16};
      ex_valid   <= (id_inst != 32'd0);
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage
// Bench for id_ex_stage. Two instances share all inputs: index 0 forwards
// from MEM (FWD_EN=1), index 1 stalls instead (FWD_EN=0). A behavioural
// model derives every output from the decode/hazard rules; a compare loop
// checks both instances each negedge, and directed cases pin literal values.
module tb_id_ex_stage;

  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] id_inst, id_pc4, rf_rs_data, rf_rt_data, mem_alu_out;
  logic        ex_reg_write, ex_mem_read, mem_reg_write, mem_mem_read, exc_flush;
  logic [4:0]  ex_write_reg, mem_write_reg;

  logic [1:0]        stall_o, is_branch_o, is_jump_o, jump_reg_o, ex_valid_o;
  logic [1:0][31:0]  branch_dst_o, jump_dst_o, ex_inst_o, ex_pc4_o;
  logic [1:0][31:0]  ex_rs_o, ex_rt_o, ex_imm_o;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.NOP_INST(NOP), .FWD_EN(1'b1)) dut_fwd (
    .clk(clk), .reset(reset), .id_inst(id_inst), .id_pc4(id_pc4),
    .rf_rs_data(rf_rs_data), .rf_rt_data(rf_rt_data),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_write_reg(ex_write_reg),
    .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read),
    .mem_write_reg(mem_write_reg), .mem_alu_out(mem_alu_out), .exc_flush(exc_flush),
    .stall(stall_o[0]), .is_branch(is_branch_o[0]), .is_jump(is_jump_o[0]),
    .jump_reg(jump_reg_o[0]), .branch_dst(branch_dst_o[0]), .jump_dst(jump_dst_o[0]),
    .ex_inst(ex_inst_o[0]), .ex_pc4(ex_pc4_o[0]), .ex_rs_data(ex_rs_o[0]),
    .ex_rt_data(ex_rt_o[0]), .ex_imm(ex_imm_o[0]), .ex_valid(ex_valid_o[0])
  );

  id_ex_stage #(.NOP_INST(NOP), .FWD_EN(1'b0)) dut_nofwd (
    .clk(clk), .reset(reset), .id_inst(id_inst), .id_pc4(id_pc4),
    .rf_rs_data(rf_rs_data), .rf_rt_data(rf_rt_data),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_write_reg(ex_write_reg),
    .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read),
    .mem_write_reg(mem_write_reg), .mem_alu_out(mem_alu_out), .exc_flush(exc_flush),
    .stall(stall_o[1]), .is_branch(is_branch_o[1]), .is_jump(is_jump_o[1]),
    .jump_reg(jump_reg_o[1]), .branch_dst(branch_dst_o[1]), .jump_dst(jump_dst_o[1]),
    .ex_inst(ex_inst_o[1]), .ex_pc4(ex_pc4_o[1]), .ex_rs_data(ex_rs_o[1]),
    .ex_rt_data(ex_rt_o[1]), .ex_imm(ex_imm_o[1]), .ex_valid(ex_valid_o[1])
  );

  typedef struct packed {
    logic        stall, is_branch, is_jump, jump_reg, jump_dec, valid;
    logic [31:0] branch_dst, jump_dst, inst, pc4, rs_data, rt_data, imm;
  } exp_t;

  localparam exp_t RESET_STATE = '{inst: NOP, default: '0};

  // Value an instruction in ID sees for register r.
  function automatic logic [31:0] readReg(input logic [4:0] r, input logic [31:0] rf_val,
                                          input bit fwd);
    if (r == 5'd0) return 32'd0;
    if (fwd && mem_reg_write && !mem_mem_read && mem_write_reg == r) return mem_alu_out;
    return rf_val;
  endfunction

  // Outputs of the stage for the current inputs: combinational outputs and
  // the value the ID/EX register takes at the next edge.
  function automatic exp_t model(input bit fwd);
    exp_t       e;
    logic [5:0] op;
    logic [5:0] funct;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] srcs[$];
    int         a;
    int         b;
    int         simm;
    bit         isBranch, isJr, isJump, cmpRt, rtUsed, taken, hz;
    op    = id_inst[31:26];
    funct = id_inst[5:0];
    rs    = id_inst[25:21];
    rt    = id_inst[20:16];
    isBranch = op inside {6'h01, 6'h04, 6'h05, 6'h06, 6'h07};
    isJr     = (op == 6'h00) && (funct == 6'h08 || funct == 6'h09);
    isJump   = (op == 6'h02) || (op == 6'h03) || isJr;
    cmpRt    = (op == 6'h04) || (op == 6'h05);
    rtUsed   = (op == 6'h00) || cmpRt || (op inside {6'h28, 6'h29, 6'h2A, 6'h2B, 6'h2E});
    a = int'(readReg(rs, rf_rs_data, fwd));
    b = int'(readReg(rt, rf_rt_data, fwd));
    simm = int'($signed(id_inst[15:0]));

    hz = 1'b0;
    if (ex_mem_read && ex_write_reg != 5'd0 &&
        (ex_write_reg == rs || (rtUsed && ex_write_reg == rt))) hz = 1'b1;
    if (isBranch || isJr) srcs.push_back(rs);
    if (cmpRt) srcs.push_back(rt);
    foreach (srcs[i]) begin
      if (srcs[i] != 5'd0) begin
        if (ex_reg_write && ex_write_reg == srcs[i]) hz = 1'b1;
        if (mem_reg_write && mem_write_reg == srcs[i] && (mem_mem_read || !fwd)) hz = 1'b1;
      end
    end

    case (op)
      6'h04:   taken = (a == b);
      6'h05:   taken = (a != b);
      6'h06:   taken = (a <= 0);
      6'h07:   taken = (a > 0);
      6'h01:   taken = rt[0] ? (a >= 0) : (a < 0);
      default: taken = 1'b0;
    endcase

    e = RESET_STATE;
    e.stall      = hz;
    e.is_branch  = isBranch && taken && !hz && !exc_flush;
    e.is_jump    = isJump && !hz && !exc_flush;
    e.jump_reg   = isJr;
    e.jump_dec   = isJump;
    e.branch_dst = id_pc4 + 32'(simm * 4);
    e.jump_dst   = isJr ? 32'(a)
                        : ((id_pc4 & 32'hF000_0000) | ((id_inst & 32'h03FF_FFFF) << 2));
    if (!exc_flush && !hz) begin
      e.inst    = id_inst;
      e.pc4     = id_pc4;
      e.rs_data = 32'(a);
      e.rt_data = 32'(b);
      e.imm     = 32'(simm);
      e.valid   = (id_inst != 32'd0);
    end
    return e;
  endfunction

  exp_t mState[2];

  always @(posedge clk or posedge reset) begin
    for (int f = 0; f < 2; f++) begin
      if (reset) mState[f] <= RESET_STATE;
      else       mState[f] <= model(f == 0);
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: actual=%h expected=%h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] inst, input logic [31:0] pc4,
                               input logic [31:0] rsd, input logic [31:0] rtd,
                               input logic exrw, input logic exmr, input logic [4:0] exwr,
                               input logic mrw, input logic mmr, input logic [4:0] mwr,
                               input logic [31:0] malu, input logic flush);
    id_inst = inst;        id_pc4 = pc4;
    rf_rs_data = rsd;      rf_rt_data = rtd;
    ex_reg_write = exrw;   ex_mem_read = exmr;   ex_write_reg = exwr;
    mem_reg_write = mrw;   mem_mem_read = mmr;   mem_write_reg = mwr;
    mem_alu_out = malu;    exc_flush = flush;
  endtask

  task automatic nextCycle;
    @(posedge clk);
    #1;
  endtask

  // Compare process: both instances against the model every negedge.
  initial begin
    exp_t c;
    forever begin
      @(negedge clk);
      for (int f = 0; f < 2; f++) begin
        c = model(f == 0);
        checkOutput($sformatf("stall/f%0d", f), 32'(stall_o[f]), 32'(c.stall));
        checkOutput($sformatf("is_branch/f%0d", f), 32'(is_branch_o[f]), 32'(c.is_branch));
        checkOutput($sformatf("is_jump/f%0d", f), 32'(is_jump_o[f]), 32'(c.is_jump));
        checkOutput($sformatf("jump_reg/f%0d", f), 32'(jump_reg_o[f]), 32'(c.jump_reg));
        checkOutput($sformatf("branch_dst/f%0d", f), branch_dst_o[f], c.branch_dst);
        if (c.jump_dec)
          checkOutput($sformatf("jump_dst/f%0d", f), jump_dst_o[f], c.jump_dst);
        checkOutput($sformatf("ex_inst/f%0d", f), ex_inst_o[f], mState[f].inst);
        checkOutput($sformatf("ex_pc4/f%0d", f), ex_pc4_o[f], mState[f].pc4);
        checkOutput($sformatf("ex_rs_data/f%0d", f), ex_rs_o[f], mState[f].rs_data);
        checkOutput($sformatf("ex_rt_data/f%0d", f), ex_rt_o[f], mState[f].rt_data);
        checkOutput($sformatf("ex_imm/f%0d", f), ex_imm_o[f], mState[f].imm);
        checkOutput($sformatf("ex_valid/f%0d", f), 32'(ex_valid_o[f]), 32'(mState[f].valid));
      end
    end
  end

  function automatic logic [4:0] pickReg();
    return ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 3));
  endfunction

  function automatic logic [31:0] pickData();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'd7;
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [31:0] genInst();
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [15:0] imm;
    rs  = pickReg();
    rt  = pickReg();
    imm = 16'($urandom);
    case ($urandom_range(0, 12))
      0:  return {6'h04, rs, rt, imm};
      1:  return {6'h05, rs, rt, imm};
      2:  return {6'h06, rs, rt, imm};
      3:  return {6'h07, rs, rt, imm};
      4:  return {6'h01, rs, rt, imm};
      5:  return {6'h02, 26'($urandom)};
      6:  return {6'h03, 26'($urandom)};
      7:  return {6'h00, rs, rt, 5'($urandom), 5'd0, ($urandom_range(0, 1) == 0) ? 6'h08 : 6'h09};
      8:  return {6'h00, rs, rt, 5'($urandom), 5'd0, 6'h20};
      9:  return {6'h23, rs, rt, imm};
      10: return {6'h2B, rs, rt, imm};
      11: return 32'd0;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Taken beq $1,$2,+3 with equal operands.
    applyStimulus(32'h1022_0003, 32'h40, 5, 5, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    checkOutput("beq_stall", 32'(stall_o[0]), 0);
    checkOutput("beq_is_branch", 32'(is_branch_o[0]), 1);
    checkOutput("beq_branch_dst", branch_dst_o[0], 32'h4C);
    nextCycle;
    checkOutput("beq_ex_inst", ex_inst_o[0], 32'h1022_0003);
    checkOutput("beq_ex_valid", 32'(ex_valid_o[0]), 1);
    checkOutput("beq_ex_imm", ex_imm_o[0], 32'h3);

    // Load-use: lw $3 in EX, add $4,$3,$5 in ID.
    applyStimulus(32'h0065_2020, 32'h44, 1, 2, 1, 1, 3, 0, 0, 0, 0, 0);
    #1;
    checkOutput("loaduse_stall", 32'(stall_o[0]), 1);
    nextCycle;
    checkOutput("loaduse_bubble_inst", ex_inst_o[0], NOP);
    checkOutput("loaduse_bubble_valid", 32'(ex_valid_o[0]), 0);
    applyStimulus(32'h0065_2020, 32'h44, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    checkOutput("loaduse_clear_stall", 32'(stall_o[0]), 0);
    nextCycle;
    checkOutput("add_ex_inst", ex_inst_o[0], 32'h0065_2020);
    checkOutput("add_ex_rt_data", ex_rt_o[0], 32'd2);

    // bne $6,$0,-1 with MEM ALU writing $6=7; rf rt reads 7 to show $0 reads 0.
    applyStimulus(32'h14C0_FFFF, 32'h200, 0, 7, 0, 0, 0, 1, 0, 6, 7, 0);
    #1;
    checkOutput("bne_fwd_stall", 32'(stall_o[0]), 0);
    checkOutput("bne_fwd_is_branch", 32'(is_branch_o[0]), 1);
    checkOutput("bne_fwd_branch_dst", branch_dst_o[0], 32'h1FC);
    checkOutput("bne_nofwd_stall", 32'(stall_o[1]), 1);
    checkOutput("bne_nofwd_is_branch", 32'(is_branch_o[1]), 0);
    nextCycle;
    checkOutput("bne_fwd_ex_rs", ex_rs_o[0], 32'd7);
    checkOutput("bne_fwd_ex_rt", ex_rt_o[0], 32'd0);
    checkOutput("bne_nofwd_bubble", ex_inst_o[1], NOP);

    // jr $31, then jal 0x40.
    applyStimulus(32'h03E0_0008, 32'h100, 32'h8000_0010, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    checkOutput("jr_is_jump", 32'(is_jump_o[0]), 1);
    checkOutput("jr_jump_reg", 32'(jump_reg_o[0]), 1);
    checkOutput("jr_jump_dst", jump_dst_o[0], 32'h8000_0010);
    nextCycle;
    applyStimulus(32'h0C00_0040, 32'h204, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    checkOutput("jal_is_jump", 32'(is_jump_o[0]), 1);
    checkOutput("jal_jump_reg", 32'(jump_reg_o[0]), 0);
    checkOutput("jal_jump_dst", jump_dst_o[0], 32'h100);
    nextCycle;
    checkOutput("jal_ex_pc4", ex_pc4_o[0], 32'h204);
    checkOutput("jal_ex_inst", ex_inst_o[0], 32'h0C00_0040);

    // Flush together with a stalled, otherwise-taken beq.
    applyStimulus(32'h1022_0003, 32'h40, 5, 5, 1, 0, 1, 0, 0, 0, 0, 1);
    #1;
    checkOutput("flush_stall", 32'(stall_o[0]), 1);
    checkOutput("flush_is_branch", 32'(is_branch_o[0]), 0);
    nextCycle;
    checkOutput("flush_ex_inst", ex_inst_o[0], NOP);
    checkOutput("flush_ex_valid", 32'(ex_valid_o[0]), 0);
    checkOutput("flush_ex_pc4", ex_pc4_o[0], 32'd0);

    // Asynchronous reset mid-cycle.
    applyStimulus(32'h1022_0003, 32'h40, 5, 5, 0, 0, 0, 0, 0, 0, 0, 0);
    nextCycle;
    checkOutput("prereset_ex_pc4", ex_pc4_o[0], 32'h40);
    #2 reset = 1'b1;
    #1;
    checkOutput("async_reset_ex_inst", ex_inst_o[0], NOP);
    checkOutput("async_reset_ex_pc4", ex_pc4_o[0], 32'd0);
    checkOutput("async_reset_ex_valid", 32'(ex_valid_o[0]), 0);
    nextCycle;
    reset = 1'b0;

    // Randomised traffic checked by the compare process.
    for (int n = 0; n < 3000; n++) begin
      nextCycle;
      reset = ($urandom_range(0, 99) == 0);
      applyStimulus(genInst(), {$urandom} & 32'hFFFF_FFFC, pickData(), pickData(),
                    1'($urandom), ($urandom_range(0, 2) == 0), pickReg(),
                    1'($urandom), ($urandom_range(0, 2) == 0), pickReg(),
                    pickData(), ($urandom_range(0, 9) == 0));
    end
    nextCycle;
    reset = 1'b0;
    repeat (2) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
